// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: merges ME commits, buffered long-op results and debug
// writes onto the single register-file write port; tracks busy registers.
module regfile_wb_sched #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m_valid,
    input  logic [5:0]  m_wbr,
    input  logic [31:0] m_res,
    input  logic        lo_issue,
    input  logic [5:0]  lo_wbr,
    output logic        lo_issue_ready,
    input  logic        lo_done_valid,
    input  logic [5:0]  lo_done_wbr,
    input  logic [31:0] lo_done_res,
    output logic        lo_done_ready,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    input  logic [5:0]  q_rs,
    input  logic [5:0]  q_rt,
    input  logic [5:0]  q_wbr,
    output logic        q_stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic [31:0] sb_busy,
    output logic [31:0] perf_port_conflict
);
    localparam logic [1:0] LP_DEPTH = 2'(FIFO_DEPTH);

    logic [4:0]  r_fifo_addr [2];
    logic [31:0] r_fifo_data [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [31:0] r_sb;
    logic        r_we;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic        r_ack;
    logic [31:0] r_perf;

    logic        w_m_real;
    logic        w_fifo_ne;
    logic [4:0]  w_head_addr;
    logic        w_head_win;
    logic        w_dbg_win;
    logic        w_enq;
    logic        w_issue_set;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_sb_n;
    logic        w_we_n;
    logic [4:0]  w_addr_n;
    logic [31:0] w_data_n;

    function automatic logic f_busy(input logic [5:0] r, input logic [31:0] sb);
        return r[5] & sb[r[4:0]];
    endfunction

    function automatic logic f_real(input logic [5:0] r);
        return r[5] & (|r[4:0]);
    endfunction

    assign w_m_real    = m_valid & f_real(m_wbr);
    assign w_fifo_ne   = (r_count != 2'd0);
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_win  = w_fifo_ne & ~w_m_real;
    // the ack cycle itself is excluded so a held request cannot win twice
    assign w_dbg_win   = dbg_req & ~w_fifo_ne & ~w_m_real & ~r_ack;

    assign lo_done_ready  = (r_count < LP_DEPTH);
    assign lo_issue_ready = ~f_busy(lo_wbr, r_sb);
    assign w_enq          = lo_done_valid & lo_done_ready & f_real(lo_done_wbr);
    assign w_issue_set    = lo_issue & lo_issue_ready & f_real(lo_wbr);

    assign w_set_mask = w_issue_set ? (32'd1 << lo_wbr[4:0]) : 32'd0;
    assign w_clr_mask = w_head_win ? (32'd1 << w_head_addr) : 32'd0;
    assign w_sb_n     = (r_sb & ~w_clr_mask) | w_set_mask;

    assign q_stall = f_busy(q_rs, r_sb) | f_busy(q_rt, r_sb)
                   | f_busy(q_wbr, r_sb);

    always_comb begin
        w_we_n   = 1'b0;
        w_addr_n = r_addr;
        w_data_n = r_data;
        if (w_m_real) begin
            w_we_n   = 1'b1;
            w_addr_n = m_wbr[4:0];
            w_data_n = m_res;
        end else if (w_head_win) begin
            w_we_n   = 1'b1;
            w_addr_n = w_head_addr;
            w_data_n = r_fifo_data[r_rd_ptr];
        end else if (w_dbg_win) begin
            w_we_n   = |dbg_addr;
            w_addr_n = dbg_addr;
            w_data_n = dbg_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_fifo_addr[r_wr_ptr] <= lo_done_wbr[4:0];
            r_fifo_data[r_wr_ptr] <= lo_done_res;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_sb     <= 32'd0;
            r_we     <= 1'b0;
            r_addr   <= 5'd0;
            r_data   <= 32'd0;
            r_ack    <= 1'b0;
            r_perf   <= 32'd0;
        end else begin
            if (w_enq)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_head_win)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_head_win};
            r_sb    <= w_sb_n;
            r_we    <= w_we_n;
            r_addr  <= w_addr_n;
            r_data  <= w_data_n;
            r_ack   <= w_dbg_win;
            if (w_m_real & w_fifo_ne)
                r_perf <= r_perf + 32'd1;
        end
    end

    assign rf_we              = r_we;
    assign rf_addr            = r_addr;
    assign rf_data            = r_data;
    assign dbg_ack            = r_ack;
    assign sb_busy            = r_sb;
    assign perf_port_conflict = r_perf;
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler for the integer register file. It merges three writers onto the single register-file write port that feeds `regs_A`/`regs_B` and the W-stage bypass:

- pipeline commits from ME, which are never stalled;
- late results from a long-latency unit (multiply/divide), buffered in a 2-entry FIFO;
- debug writes, via a request/acknowledge handshake.

It also keeps a 32-bit busy scoreboard of registers awaiting a long-latency result and gives DE a combinational stall query.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: long-op result buffer depth; only the value 2 is supported.

Ports:
- `clock`  in  1  single clock; all state on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m_valid`  in  1  ME commit valid.
- `m_wbr`  in  6  ME destination; bit 5 = real write, [4:0] = register.
- `m_res`  in  32  ME result.
- `lo_issue`  in  1  long op issuing, destination `lo_wbr`.
- `lo_wbr`  in  6  long-op destination (same encoding as `m_wbr`).
- `lo_issue_ready`  out  1  issue accepted this cycle when high.
- `lo_done_valid`  in  1  long-op result valid.
- `lo_done_wbr`  in  6  result destination.
- `lo_done_res`  in  32  result value.
- `lo_done_ready`  out  1  FIFO can accept.
- `dbg_req`  in  1  debug write request, held until ack.
- `dbg_addr`  in  5  debug register.
- `dbg_wdata`  in  32  debug data.
- `dbg_ack`  out  1  one-cycle acknowledge.
- `q_rs`, `q_rt`, `q_wbr`  in  6 each  DE operand/destination query.
- `q_stall`  out  1  query hits a busy register.
- `rf_we`  out  1  register-file write enable.
- `rf_addr`  out  5  write address.
- `rf_data`  out  32  write data.
- `sb_busy`  out  32  scoreboard.
- `perf_port_conflict`  out  32  conflict counter.

## Operation
Arbitration happens in each cycle t. A source is eligible only if its destination is a real write (bit 5 set and [4:0] ≠ 0). Sources, highest priority first:
- Commit: `m_valid & m_wbr[5]`.
- FIFO head, if the FIFO is non-empty.
- Debug: `dbg_req` with the FIFO empty.

Winner registration:
- The winner is registered into `rf_we`/`rf_addr`/`rf_data`, visible in cycle t+1.
- If there is no winner, `rf_we` is 0.

FIFO:
- Enqueue when `lo_done_valid & lo_done_ready`.
- `lo_done_ready = (count < 2)` is computed from the pre-update count. A simultaneous dequeue does not free a slot in the same cycle.
- An entry with a non-real destination is accepted and dropped. It does not enter the FIFO and does not touch the scoreboard.
- Dequeue when the head wins arbitration.

Scoreboard:
- `lo_issue_ready = ~(lo_wbr[5] & sb_busy[lo_wbr[4:0]])`.
- On `lo_issue & lo_issue_ready` with a real destination, set the busy bit for that register.
- When a FIFO head wins, clear its bit.
- Set and clear of the same bit in one cycle cannot occur, because issue is blocked while the bit is busy.
- A commit to a busy register writes normally and leaves the bit set. DE must prevent this (write-after-write) through `q_stall`.

`q_stall` (combinational):
- It is the OR, over `q_rs`, `q_rt` and `q_wbr`, of (bit 5 & `sb_busy[bits 4:0]`).

Debug:
- `dbg_ack` is 1 in cycle t+1 after debug wins in cycle t.
- A request with `dbg_addr == 0` wins whenever the port is idle and the FIFO is empty, is acked, and performs no write (`rf_we` = 0).
- The requester drops `dbg_req` on the ack cycle; debug may win again only in the following cycle.
- Debug may be starved by commits; it is intended for use with the pipeline halted.

`perf_port_conflict` increments, with wraparound, in every cycle where a commit wins while the FIFO is non-empty.

## Timing
- Reset (asynchronous, while `reset_n` = 0):
  - `rf_we` = 0, `rf_addr` = 0, `rf_data` = 0;
  - `dbg_ack` = 0, `sb_busy` = 0, `perf_port_conflict` = 0;
  - FIFO emptied, so `lo_done_ready` = 1 and `lo_issue_ready` = 1.
  - Reset mid-operation discards pending results and busy bits.
- Commit latency: `m_*` in cycle t appears on `rf_*` in cycle t+1.
- Long-op result latency:
  - enqueued at the end of cycle t, head visible in t+1, on `rf_*` in t+2 at the earliest;
  - delayed one further cycle per intervening commit.
- Busy bit timing:
  - the bit clears in the register update of the head's winning cycle (visible in t+2 with `rf_we`);
  - `q_stall` releases in that same cycle, when DE's regfile read coincides with the write, and the W bypass covers it.
- FIFO order is strict FIFO; long-op results are never reordered.

## Test plan
- Commit alone: `m_valid`=1, `m_wbr`=6'h25, `m_res`=32'hDEADBEEF at t → `rf_we`=1, `rf_addr`=5, `rf_data`=32'hDEADBEEF at t+1.
- Long op with no conflict: issue `lo_wbr`=6'h23 → `sb_busy[3]`=1 and `q_stall`=1 for `q_rs`=6'h23. Result 32'h1234 at t → on `rf_*` at t+2; `sb_busy[3]`=0 at t+2.
- Conflict: the result enqueued at t is the FIFO head at t+1, while commits occur in cycles t+1 through t+3 → long-op write on `rf_*` at t+5; `perf_port_conflict`=3.
- FIFO full: two results held under continuous commits → `lo_done_ready`=0; a third `lo_done_valid` is ignored until a slot drains.
- Blocked issue: `lo_issue` to a busy register → `lo_issue_ready`=0 and no state change.
- Debug and reset:
  - `dbg_req`, addr 7, data 32'h55 with the port idle → `rf_we` at t+1 and `dbg_ack` pulse at t+1.
  - `reset_n` asserted low with the FIFO non-empty → `sb_busy`=0 and `lo_done_ready`=1 immediately; no write emerges after release.
